// File: rtl/trs80_dl_pkg.sv
// Shared types and defaults for the ioctl download buffer.
// Holds the FSM state enum, FIFO entry layout and default sizing.
package trs80_dl_pkg;

    localparam int DL_DEPTH       = 16;
    localparam int DL_WAIT_MARGIN = 4;
    localparam int DL_AW          = 16;
    localparam int DL_IW          = 16;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        DONE
    } dl_state_t;

    // The wrapper packs {addr, data} in this order for any AW.
    typedef struct packed {
        logic [DL_AW-1:0] addr;
        logic [7:0]       data;
    } dl_entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO, async active-high reset.
// Ports: push/wdata, pop/rdata, full, empty, free (entries available).
module sync_fifo_fwft #(
    parameter int DEPTH = 16,
    parameter int W     = 24
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] free
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // Flags come from the registered count only, so a pop in the
    // same cycle never makes room for a push into a full FIFO.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign free    = CW'(DEPTH) - count;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ioctl_dl_buffer.sv
// Elastic buffer from the hps_io ioctl download port to a valid/ready
// consumer. Ports: ioctl_* in, ioctl_wait out, dl_* stream and framing.
module ioctl_dl_buffer
    import trs80_dl_pkg::*;
#(
    parameter int DEPTH       = DL_DEPTH,
    parameter int AW          = DL_AW,
    parameter int IW          = DL_IW,
    parameter int WAIT_MARGIN = DL_WAIT_MARGIN
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic [IW-1:0] ioctl_index,
    output logic          ioctl_wait,
    output logic          dl_valid,
    input  logic          dl_ready,
    output logic [AW-1:0] dl_addr,
    output logic [7:0]    dl_data,
    output logic [IW-1:0] dl_index,
    output logic          dl_active,
    output logic          dl_done,
    output logic [AW:0]   dl_bytes,
    output logic [7:0]    dl_sum,
    output logic          dl_overflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = AW + 8;

    dl_state_t     state;
    dl_state_t     state_nx;
    logic          dl_prev;
    logic          pending;
    logic          rise;
    logic          start;
    logic          push_req;
    logic          acc;
    logic          rej;
    logic          full;
    logic          empty;
    logic [CW-1:0] free;
    logic [EW-1:0] rdata;

    assign rise     = ioctl_download & ~dl_prev;
    // A pending start is taken as soon as the previous frame retires.
    assign start    = (state == IDLE) & (rise | pending);
    assign push_req = ioctl_download & ioctl_wr
                    & (start | (state == FILL));
    assign acc      = push_req & ~full;
    assign rej      = push_req & full;

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (push_req),
        .wdata   ({ioctl_addr, ioctl_dout}),
        .pop     (dl_ready),
        .rdata   (rdata),
        .full    (full),
        .empty   (empty),
        .free    (free)
    );

    assign dl_valid   = ~empty;
    assign dl_addr    = rdata[EW-1:8];
    assign dl_data    = rdata[7:0];
    assign dl_done    = (state == DONE);
    assign dl_active  = (state != IDLE);
    assign ioctl_wait = (free <= CW'(WAIT_MARGIN)) | pending;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FILL;
            // Level test also covers a download that ended while pending.
            FILL:    if (!ioctl_download) state_nx = DRAIN;
            DRAIN:   if (empty && !acc) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            dl_prev     <= 1'b1;
            pending     <= 1'b0;
            dl_index    <= '0;
            dl_bytes    <= '0;
            dl_sum      <= '0;
            dl_overflow <= 1'b0;
        end else begin
            state   <= state_nx;
            dl_prev <= ioctl_download;
            if (start) begin
                pending  <= 1'b0;
                dl_index <= ioctl_index;
            end else if (rise && (state == DRAIN || state == DONE)) begin
                pending <= 1'b1;
            end
            if (start) begin
                dl_bytes    <= acc ? (AW+1)'(1) : '0;
                dl_sum      <= acc ? ioctl_dout : 8'h00;
                dl_overflow <= rej;
            end else begin
                if (acc) begin
                    dl_bytes <= dl_bytes + (AW+1)'(1);
                    dl_sum   <= dl_sum + ioctl_dout;
                end
                if (rej) begin
                    dl_overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ioctl_dl_buffer.sv
// Directed self-checking bench for ioctl_dl_buffer.
// Covers ordering, wait throttling, overflow, pending start, reset, empty.
module tb_ioctl_dl_buffer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [15:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] ioctl_index;
    logic        ioctl_wait;
    logic        dl_valid;
    logic        dl_ready;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic [15:0] dl_index;
    logic        dl_active;
    logic        dl_done;
    logic [16:0] dl_bytes;
    logic [7:0]  dl_sum;
    logic        dl_overflow;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [15:0] q_addr[$];
    logic [7:0]  q_data[$];

    ioctl_dl_buffer dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .dl_valid       (dl_valid),
        .dl_ready       (dl_ready),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .dl_index       (dl_index),
        .dl_active      (dl_active),
        .dl_done        (dl_done),
        .dl_bytes       (dl_bytes),
        .dl_sum         (dl_sum),
        .dl_overflow    (dl_overflow)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (dl_done) done_cnt <= done_cnt + 1;
        if (dl_valid && dl_ready) begin
            q_addr.push_back(dl_addr);
            q_data.push_back(dl_data);
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!dl_done && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(dl_done), 32'd1);
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_data.delete();
    endtask

    initial begin
        int errs;
        int d0;
        int drop;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ioctl_index    = '0;
        dl_ready       = 1'b0;
        tick();
        tick();
        chk("rst_wait", 32'(ioctl_wait), 0);
        chk("rst_valid", 32'(dl_valid), 0);
        chk("rst_active", 32'(dl_active), 0);
        chk("rst_done", 32'(dl_done), 0);
        chk("rst_bytes", 32'(dl_bytes), 0);
        chk("rst_sum", 32'(dl_sum), 0);
        chk("rst_ovf", 32'(dl_overflow), 0);
        chk("rst_index", 32'(dl_index), 0);
        reset = 1'b0;
        tick();

        // 1: three bytes, consumer always ready
        clear_q();
        dl_ready       = 1'b1;
        ioctl_index    = 16'h0011;
        ioctl_download = 1'b1;
        tick();
        chk("t1_active", 32'(dl_active), 1);
        wr(16'h0000, 8'hA5);
        wr(16'h0001, 8'h5A);
        wr(16'h0002, 8'h01);
        ioctl_download = 1'b0;
        d0 = done_cnt;
        tick();
        wait_done("t1_done");
        chk("t1_bytes", 32'(dl_bytes), 3);
        chk("t1_sum", 32'(dl_sum), 8'h00);
        chk("t1_index", 32'(dl_index), 16'h0011);
        tick(); tick(); tick();
        chk("t1_done_once", 32'(done_cnt - d0), 1);
        chk("t1_active_off", 32'(dl_active), 0);
        chk("t1_count", 32'(q_data.size()), 3);
        if (q_data.size() == 3) begin
            chk("t1_d0", {q_addr[0], 8'h0, q_data[0]}, 32'h0000_00A5);
            chk("t1_d1", {q_addr[1], 8'h0, q_data[1]}, 32'h0001_005A);
            chk("t1_d2", {q_addr[2], 8'h0, q_data[2]}, 32'h0002_0001);
        end

        // 2: 20 writes, stalled consumer, driver honours wait
        clear_q();
        dl_ready       = 1'b0;
        ioctl_index    = 16'h0022;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            if (i == 11) chk("t2_wait_11", 32'(ioctl_wait), 0);
            wr(16'(i), 8'(8'h10 + i));
        end
        chk("t2_wait_12", 32'(ioctl_wait), 1);
        dl_ready = 1'b1;
        for (int i = 12; i < 20; i++) begin
            int g = 0;
            while (ioctl_wait && g < 100) begin
                tick();
                g++;
            end
            wr(16'(i), 8'(8'h10 + i));
        end
        ioctl_download = 1'b0;
        tick();
        wait_done("t2_done");
        chk("t2_bytes", 32'(dl_bytes), 20);
        chk("t2_sum", 32'(dl_sum), 8'hFE);
        chk("t2_ovf", 32'(dl_overflow), 0);
        chk("t2_count", 32'(q_data.size()), 20);
        errs = 0;
        for (int i = 0; i < q_data.size(); i++) begin
            if (q_data[i] !== 8'(8'h10 + i)) errs++;
            if (q_addr[i] !== 16'(i)) errs++;
        end
        chk("t2_order", 32'(errs), 0);
        tick();

        // 3: 17 writes ignoring wait
        clear_q();
        dl_ready       = 1'b0;
        ioctl_index    = 16'h0033;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            wr(16'(16'h0100 + i), 8'(i + 1));
        end
        chk("t3_ovf", 32'(dl_overflow), 1);
        chk("t3_bytes", 32'(dl_bytes), 16);
        chk("t3_sum", 32'(dl_sum), 8'h88);
        chk("t3_wait", 32'(ioctl_wait), 1);
        chk("t3_valid", 32'(dl_valid), 1);

        // 4: next download rises with 5 entries left
        ioctl_download = 1'b0;
        tick();
        dl_ready = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        dl_ready = 1'b0;
        chk("t4_wait_low", 32'(ioctl_wait), 0);
        ioctl_index    = 16'h0044;
        ioctl_download = 1'b1;
        tick();
        chk("t4_wait_pend", 32'(ioctl_wait), 1);
        chk("t4_index_old", 32'(dl_index), 16'h0033);
        dl_ready = 1'b1;
        drop = 0;
        for (int n = 0; n < 100 && !dl_done; n++) begin
            if (!ioctl_wait) drop = 1;
            tick();
        end
        chk("t4_done", 32'(dl_done), 1);
        chk("t4_wait_held", 32'(drop), 0);
        chk("t4_bytes_old", 32'(dl_bytes), 16);
        chk("t4_count", 32'(q_data.size()), 16);
        if (q_data.size() == 16) begin
            chk("t4_last", {q_addr[15], 8'h0, q_data[15]},
                32'h010F_0010);
        end
        tick();
        tick();
        chk("t4_index_new", 32'(dl_index), 16'h0044);
        chk("t4_bytes_new", 32'(dl_bytes), 0);
        chk("t4_ovf_new", 32'(dl_overflow), 0);
        chk("t4_wait_new", 32'(ioctl_wait), 0);
        chk("t4_active", 32'(dl_active), 1);
        wr(16'h0200, 8'h20);
        wr(16'h0201, 8'h30);
        ioctl_download = 1'b0;
        tick();
        wait_done("t4_done2");
        chk("t4_bytes2", 32'(dl_bytes), 2);
        chk("t4_sum2", 32'(dl_sum), 8'h50);
        tick();

        // 5: reset mid-download
        dl_ready       = 1'b0;
        ioctl_index    = 16'h0055;
        ioctl_download = 1'b1;
        tick();
        wr(16'h0300, 8'h11);
        wr(16'h0301, 8'h22);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("t5_valid", 32'(dl_valid), 0);
        chk("t5_active", 32'(dl_active), 0);
        chk("t5_bytes", 32'(dl_bytes), 0);
        chk("t5_index", 32'(dl_index), 0);
        chk("t5_wait", 32'(ioctl_wait), 0);
        wr(16'h0302, 8'h33);
        wr(16'h0303, 8'h44);
        wr(16'h0304, 8'h55);
        chk("t5_valid_ign", 32'(dl_valid), 0);
        chk("t5_bytes_ign", 32'(dl_bytes), 0);
        chk("t5_ovf_ign", 32'(dl_overflow), 0);
        d0 = done_cnt;
        ioctl_download = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_no_done", 32'(done_cnt - d0), 0);
        clear_q();
        dl_ready       = 1'b1;
        ioctl_index    = 16'h0066;
        ioctl_download = 1'b1;
        tick();
        wr(16'h0100, 8'h77);
        ioctl_download = 1'b0;
        tick();
        wait_done("t5_done");
        chk("t5_bytes2", 32'(dl_bytes), 1);
        chk("t5_sum2", 32'(dl_sum), 8'h77);
        chk("t5_index2", 32'(dl_index), 16'h0066);
        chk("t5_count", 32'(q_data.size()), 1);
        if (q_data.size() == 1) begin
            chk("t5_entry", {q_addr[0], 8'h0, q_data[0]},
                32'h0100_0077);
        end
        tick();

        // 6: zero-byte download
        ioctl_index    = 16'h0007;
        ioctl_download = 1'b1;
        tick();
        ioctl_download = 1'b0;
        tick();
        wait_done("t6_done");
        chk("t6_bytes", 32'(dl_bytes), 0);
        chk("t6_sum", 32'(dl_sum), 0);
        chk("t6_index", 32'(dl_index), 16'h0007);
        tick();
        chk("t6_idle", 32'(dl_active), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
